// File: rtl/ex_mopa_unit.sv
// Matrix outer-product-accumulate engine: M += a (x) b, one row per cycle.
// It stalls the front end while busy and returns all four rows with a one-cycle done strobe.
//
// state | meaning
// IDLE  | waiting for mopa_start
// CALC  | computing row `row`, writing it to mopa_result[row]
// DONE  | done strobe, all rows final; may accept a back-to-back start
module ex_mopa_unit #(
    parameter int SAT_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mopa_start,
    input  logic [31:0]      mopa_a,
    input  logic [31:0]      mopa_b,
    input  logic [3:0][31:0] mopa_acc_in,
    input  logic             flush,
    output logic             mopa_stall,
    output logic             mopa_busy,
    output logic             mopa_done,
    output logic [3:0][31:0] mopa_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       row, row_nxt;
    logic             load_new, load_fwd, wr_row;
    logic [31:0]      a_q, b_q;
    logic [3:0][31:0] acc_q;
    logic [7:0]       a_el;
    logic [31:0]      row_res;

    function automatic logic [7:0] mac8(input logic [7:0] acc, input logic [7:0] a,
                                        input logic [7:0] b);
        logic signed [15:0] prod;
        logic signed [16:0] sum;
        prod = $signed(a) * $signed(b);
        sum  = $signed({{9{acc[7]}}, acc}) + $signed({prod[15], prod});
        if (SAT_EN != 0) begin
            if (sum > 17'sd127)  return 8'h7F;
            if (sum < -17'sd128) return 8'h80;
        end
        return sum[7:0];
    endfunction

    assign a_el = a_q[{row, 3'b000} +: 8];

    always_comb begin
        row_res = '0;
        for (int j = 0; j < 4; j++) begin
            row_res[j*8 +: 8] = mac8(acc_q[row][j*8 +: 8], a_el, b_q[j*8 +: 8]);
        end
    end

    always_comb begin
        state_nxt  = state;
        row_nxt    = row;
        load_new   = 1'b0;
        load_fwd   = 1'b0;
        wr_row     = 1'b0;
        mopa_done  = 1'b0;
        mopa_stall = 1'b0;
        case (state)
            IDLE: begin
                mopa_stall = mopa_start;
                if (mopa_start && !flush) begin
                    state_nxt = CALC;
                    row_nxt   = 2'd0;
                    load_new  = 1'b1;
                end
            end
            CALC: begin
                mopa_stall = 1'b1;
                if (!flush) begin
                    wr_row  = 1'b1;
                    row_nxt = row + 2'd1;
                    if (row == 2'd3) state_nxt = DONE;
                end
            end
            DONE: begin
                mopa_stall = mopa_start;
                if (!flush) begin
                    mopa_done = 1'b1;
                    if (mopa_start) begin
                        state_nxt = CALC;
                        row_nxt   = 2'd0;
                        load_fwd  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            row_nxt   = 2'd0;
        end
    end

    assign mopa_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            row   <= 2'd0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
        end
    end

    // Back-to-back starts accumulate onto our own result: the matrix file
    // write lands on the same edge, so mopa_acc_in would still be stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            mopa_result <= '0;
        end else begin
            if (load_new) begin
                a_q   <= mopa_a;
                b_q   <= mopa_b;
                acc_q <= mopa_acc_in;
            end else if (load_fwd) begin
                a_q   <= mopa_a;
                b_q   <= mopa_b;
                acc_q <= mopa_result;
            end
            if (wr_row) mopa_result[row] <= row_res;
        end
    end

endmodule

// File: tb/tb_ex_mopa_unit.sv
// Directed bench for ex_mopa_unit; a wrapping and a saturating instance share all stimulus.
module tb_ex_mopa_unit;

    logic             clk;
    logic             rst;
    logic             mopa_start;
    logic [31:0]      mopa_a, mopa_b;
    logic [3:0][31:0] mopa_acc_in;
    logic             flush;
    logic             stall0, busy0, done0, stall1, busy1, done1;
    logic [3:0][31:0] res0, res1;

    int vectors = 0;
    int miscompares = 0;

    ex_mopa_unit #(.SAT_EN(0)) dut0 (
        .clk(clk), .rst(rst), .mopa_start(mopa_start), .mopa_a(mopa_a), .mopa_b(mopa_b),
        .mopa_acc_in(mopa_acc_in), .flush(flush), .mopa_stall(stall0), .mopa_busy(busy0),
        .mopa_done(done0), .mopa_result(res0)
    );

    ex_mopa_unit #(.SAT_EN(1)) dut1 (
        .clk(clk), .rst(rst), .mopa_start(mopa_start), .mopa_a(mopa_a), .mopa_b(mopa_b),
        .mopa_acc_in(mopa_acc_in), .flush(flush), .mopa_stall(stall1), .mopa_busy(busy1),
        .mopa_done(done1), .mopa_result(res1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0][31:0] acc);
        mopa_a      = a;
        mopa_b      = b;
        mopa_acc_in = acc;
    endtask

    // Pulse start for one cycle; returns just after the sampling edge.
    task automatic pulse_start();
        mopa_start = 1'b1;
        @(posedge clk); #1;
        mopa_start = 1'b0;
    endtask

    // Returns the cycle count at which done0 is seen, or -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; mopa_start = 1'b0; flush = 1'b0;
        set_ops(32'h0, 32'h0, '0);
        #12;
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done0); end
        vectors++; if (stall0 !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", stall0); end
        vectors++; if (res0 !== 128'h0) begin miscompares++; $display("FAIL reset_result: got %h expected 0", res0); end
        mopa_start = 1'b1; #1;
        vectors++; if (stall0 !== 1'b1) begin miscompares++; $display("FAIL reset_stall_start: got %b expected 1", stall0); end
        mopa_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        set_ops(32'h04030201, 32'h01010101, '0);
        mopa_start = 1'b1;
        @(negedge clk);
        vectors++; if (stall0 !== 1'b1) begin miscompares++; $display("FAIL basic_stall_T: got %b expected 1", stall0); end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL basic_busy_T: got %b expected 0", busy0); end
        @(posedge clk); #1;
        mopa_start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            vectors++; if (done0 !== (k == 5)) begin miscompares++; $display("FAIL basic_done c%0d: got %b expected %b", k, done0, (k == 5)); end
            vectors++; if (stall0 !== (k < 5)) begin miscompares++; $display("FAIL basic_stall c%0d: got %b expected %b", k, stall0, (k < 5)); end
            vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL basic_busy c%0d: got %b expected 1", k, busy0); end
        end
        vectors++; if (res0 !== {32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101}) begin
            miscompares++; $display("FAIL basic_result: got %h expected 04040404030303030202020201010101", res0); end
        @(negedge clk);
        vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL basic_done_after: got %b expected 0", done0); end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after: got %b expected 0", busy0); end
        vectors++; if (res0[3] !== 32'h04040404) begin miscompares++; $display("FAIL basic_hold: got %h expected 04040404", res0[3]); end
        @(posedge clk); #1;
    endtask

    task automatic test_signed();
        int lat;
        set_ops(32'h000000FF, 32'h00000005, '0);
        pulse_start();
        wait_done(lat);
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL signed_latency: got %0d expected 5", lat); end
        vectors++; if (res0 !== {32'h0, 32'h0, 32'h0, 32'h000000FB}) begin
            miscompares++; $display("FAIL signed_result: got %h expected 000...000000FB", res0); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        int lat;
        set_ops(32'h0000007F, 32'h00000002, {32'h0, 32'h0, 32'h0, 32'h00000001});
        pulse_start();
        wait_done(lat);
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL ovf_latency: got %0d expected 5", lat); end
        vectors++; if (res0[0] !== 32'h000000FF) begin miscompares++; $display("FAIL ovf_wrap: got %h expected 000000FF", res0[0]); end
        vectors++; if (res1[0] !== 32'h0000007F) begin miscompares++; $display("FAIL ovf_sat: got %h expected 0000007F", res1[0]); end
        vectors++; if (done1 !== 1'b1) begin miscompares++; $display("FAIL ovf_sat_done: got %b expected 1", done1); end
        @(posedge clk); #1;
        set_ops(32'h00000080, 32'h0000007F, {32'h0, 32'h0, 32'h0, 32'h00000080});
        pulse_start();
        wait_done(lat);
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL neg_latency: got %0d expected 5", lat); end
        vectors++; if (res1[0] !== 32'h00000080) begin miscompares++; $display("FAIL neg_sat: got %h expected 00000080", res1[0]); end
        vectors++; if (res0[0] !== 32'h00000000) begin miscompares++; $display("FAIL neg_wrap: got %h expected 00000000", res0[0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        set_ops(32'h04030201, 32'h01010101, '0);
        pulse_start();
        wait_done(lat);
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL b2b_first_latency: got %0d expected 5", lat); end
        mopa_start = 1'b1;
        #1;
        vectors++; if (stall0 !== 1'b1) begin miscompares++; $display("FAIL b2b_stall_done: got %b expected 1", stall0); end
        @(posedge clk); #1;
        mopa_start = 1'b0;
        wait_done(lat);
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL b2b_second_latency: got %0d expected 5", lat); end
        vectors++; if (res0[0] !== 32'h02020202) begin miscompares++; $display("FAIL b2b_row0: got %h expected 02020202", res0[0]); end
        vectors++; if (res0[3] !== 32'h08080808) begin miscompares++; $display("FAIL b2b_row3: got %h expected 08080808", res0[3]); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int seen_done;
        do_reset();
        set_ops(32'h04030201, 32'h01010101, '0);
        pulse_start();
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL flush_busy: got %b expected 0", busy0); end
        vectors++; if (stall0 !== 1'b0) begin miscompares++; $display("FAIL flush_stall: got %b expected 0", stall0); end
        seen_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done0 === 1'b1) seen_done++;
        end
        vectors++; if (seen_done !== 0) begin miscompares++; $display("FAIL flush_no_done: got %0d strobes expected 0", seen_done); end
        vectors++; if (res0 !== {32'h0, 32'h0, 32'h0, 32'h01010101}) begin
            miscompares++; $display("FAIL flush_result: got %h expected 000...01010101", res0); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        int lat;
        set_ops(32'h04030201, 32'h01010101, '0);
        pulse_start();
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1;
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", busy0); end
        vectors++; if (stall0 !== 1'b0) begin miscompares++; $display("FAIL rstmid_stall: got %b expected 0", stall0); end
        vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL rstmid_done: got %b expected 0", done0); end
        vectors++; if (res0 !== 128'h0) begin miscompares++; $display("FAIL rstmid_result: got %h expected 0", res0); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        wait_done(lat);
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL rstmid_restart_latency: got %0d expected 5", lat); end
        vectors++; if (res0[3] !== 32'h04040404) begin miscompares++; $display("FAIL rstmid_restart_row3: got %h expected 04040404", res0[3]); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
